// File: rtl/nv_nvdla_sdp_rdma_pkg.sv
// rtl/nv_nvdla_sdp_rdma_pkg.sv - shared widths, depth and payload types for the SDP RDMA slice
package nv_nvdla_sdp_rdma_pkg;

    localparam int SDP_RDMA_REQ_PW         = 79;
    localparam int SDP_RDMA_RSP_PW         = 514;
    localparam int SDP_RDMA_LAT_FIFO_DEPTH = 16;

    typedef logic [SDP_RDMA_REQ_PW-1:0] sdp_rdma_req_pd_t;
    typedef logic [SDP_RDMA_RSP_PW-1:0] sdp_rdma_rsp_pd_t;

    // Index width of a power-of-two FIFO; pointers carry one extra wrap bit.
    function automatic int lat_fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rdma_lat_fifo.sv
// rtl/nv_nvdla_sdp_rdma_lat_fifo.sv - latency FIFO with wrap-bit pointers and flop-based output
module nv_nvdla_sdp_rdma_lat_fifo
    import nv_nvdla_sdp_rdma_pkg::*;
#(
    parameter int DEPTH = SDP_RDMA_LAT_FIFO_DEPTH,
    parameter int WIDTH = SDP_RDMA_RSP_PW
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [WIDTH-1:0] wr_pd,
    input  logic             wr_vld,
    output logic             wr_rdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic             full,
    output logic             empty
);

    localparam int AW = lat_fifo_aw(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Full when indices match but the wrap bits differ; empty when pointers are identical.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);

    // Ready reflects the pre-pop state, so a full FIFO never takes a write even when popping.
    assign wr_rdy = !full;
    assign wr_en  = wr_vld && !full;
    assign rd_vld = !empty;
    assign rd_en  = rd_vld && rd_rdy;

    // Head entry comes straight from storage flops; it cannot change until it is popped.
    assign rd_pd  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; reset drops every buffered entry.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; data needs no reset because the pointers define validity.
    always_ff @(posedge nvdla_core_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_pd;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_lat_fifo_ctrl.sv
// rtl/nv_nvdla_sdp_rdma_lat_fifo_ctrl.sv - credit-gated request pass-through with response latency FIFO
module nv_nvdla_sdp_rdma_lat_fifo_ctrl
    import nv_nvdla_sdp_rdma_pkg::*;
#(
    parameter int DEPTH  = SDP_RDMA_LAT_FIFO_DEPTH,
    parameter int REQ_PW = SDP_RDMA_REQ_PW,
    parameter int RSP_PW = SDP_RDMA_RSP_PW,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic [REQ_PW-1:0] req_pd,
    input  logic              req_vld,
    output logic              req_rdy,
    output logic [REQ_PW-1:0] dma_rd_req_pd,
    output logic              dma_rd_req_vld,
    input  logic              dma_rd_req_rdy,
    input  logic [RSP_PW-1:0] dma_rd_rsp_pd,
    input  logic              dma_rd_rsp_vld,
    output logic              dma_rd_rsp_rdy,
    output logic [RSP_PW-1:0] rsp_pd,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic              dma_rd_cdt_lat_fifo_pop,
    output logic [CNT_W-1:0]  credit_cnt,
    output logic              idle,
    output logic              err_ovf
);

    logic credit_ok;
    logic req_acc;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    // A request may leave only while a FIFO slot is reserved for its response.
    // The gate uses the registered count, so a same-cycle pop at zero credits
    // frees the slot only from the next cycle on.
    assign credit_ok      = (credit_cnt != '0);
    assign dma_rd_req_pd  = req_pd;
    assign dma_rd_req_vld = req_vld && credit_ok;
    assign req_rdy        = dma_rd_req_rdy && credit_ok;
    assign req_acc        = req_vld && req_rdy;
    assign pop            = rsp_vld && rsp_rdy;

    assign idle = (credit_cnt == CNT_W'(DEPTH)) && fifo_empty && !dma_rd_cdt_lat_fifo_pop;

    // Credit bookkeeping, credit-return pulse and sticky overflow flag.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            credit_cnt              <= CNT_W'(DEPTH);
            dma_rd_cdt_lat_fifo_pop <= 1'b0;
            err_ovf                 <= 1'b0;
        end else begin
            credit_cnt              <= credit_cnt - CNT_W'(req_acc) + CNT_W'(pop);
            dma_rd_cdt_lat_fifo_pop <= pop;
            if (dma_rd_rsp_vld && fifo_full) begin
                err_ovf <= 1'b1;
            end
        end
    end

    nv_nvdla_sdp_rdma_lat_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RSP_PW)
    ) u_lat_fifo (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .wr_pd          (dma_rd_rsp_pd),
        .wr_vld         (dma_rd_rsp_vld),
        .wr_rdy         (dma_rd_rsp_rdy),
        .rd_pd          (rsp_pd),
        .rd_vld         (rsp_vld),
        .rd_rdy         (rsp_rdy),
        .full           (fifo_full),
        .empty          (fifo_empty)
    );

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_lat_fifo_ctrl.sv
// tb/tb_nv_nvdla_sdp_rdma_lat_fifo_ctrl.sv - randomized self-checking bench with queue-based reference model
module tb_nv_nvdla_sdp_rdma_lat_fifo_ctrl;
    import nv_nvdla_sdp_rdma_pkg::*;

    localparam int DEPTH  = 16;
    localparam int REQ_PW = SDP_RDMA_REQ_PW;
    localparam int RSP_PW = SDP_RDMA_RSP_PW;
    localparam int CNT_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    sdp_rdma_req_pd_t  req_pd = '0;
    logic              req_vld = 1'b0;
    logic              req_rdy;
    sdp_rdma_req_pd_t  dma_rd_req_pd;
    logic              dma_rd_req_vld;
    logic              dma_rd_req_rdy = 1'b0;
    sdp_rdma_rsp_pd_t  dma_rd_rsp_pd = '0;
    logic              dma_rd_rsp_vld = 1'b0;
    logic              dma_rd_rsp_rdy;
    sdp_rdma_rsp_pd_t  rsp_pd;
    logic              rsp_vld;
    logic              rsp_rdy = 1'b0;
    logic              cdt_pop;
    logic [CNT_W-1:0]  credit_cnt;
    logic              idle;
    logic              err_ovf;

    nv_nvdla_sdp_rdma_lat_fifo_ctrl #(
        .DEPTH  (DEPTH),
        .REQ_PW (REQ_PW),
        .RSP_PW (RSP_PW),
        .CNT_W  (CNT_W)
    ) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rst          (rst),
        .req_pd                  (req_pd),
        .req_vld                 (req_vld),
        .req_rdy                 (req_rdy),
        .dma_rd_req_pd           (dma_rd_req_pd),
        .dma_rd_req_vld          (dma_rd_req_vld),
        .dma_rd_req_rdy          (dma_rd_req_rdy),
        .dma_rd_rsp_pd           (dma_rd_rsp_pd),
        .dma_rd_rsp_vld          (dma_rd_rsp_vld),
        .dma_rd_rsp_rdy          (dma_rd_rsp_rdy),
        .rsp_pd                  (rsp_pd),
        .rsp_vld                 (rsp_vld),
        .rsp_rdy                 (rsp_rdy),
        .dma_rd_cdt_lat_fifo_pop (cdt_pop),
        .credit_cnt              (credit_cnt),
        .idle                    (idle),
        .err_ovf                 (err_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: buffered responses, due cycles of outstanding responses,
    // free credits as DEPTH minus outstanding, last-cycle pop, overflow seen.
    sdp_rdma_rsp_pd_t m_q[$];
    int               pend[$];
    int               m_cred = DEPTH;
    bit               m_cdt  = 1'b0;
    bit               m_err  = 1'b0;

    int               cyc      = 0;
    bit               chk_en   = 1'b0;
    bit               auto_rsp = 1'b0;
    bit               rsp_rand = 1'b0;
    int               del_min  = 3;
    int               del_max  = 3;
    int               acc_cnt  = 0;
    int               cdt_cnt  = 0;
    bit               prev_stall = 1'b0;
    sdp_rdma_rsp_pd_t prev_pd  = '0;

    task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_pd(input string nm, input sdp_rdma_rsp_pd_t act, input sdp_rdma_rsp_pd_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic sdp_rdma_req_pd_t rand_req();
        sdp_rdma_req_pd_t v;
        for (int i = 0; i < REQ_PW; i++) v[i] = 1'($urandom_range(1, 0));
        return v;
    endfunction

    function automatic sdp_rdma_rsp_pd_t rand_rsp();
        sdp_rdma_rsp_pd_t v;
        for (int i = 0; i < RSP_PW; i++) v[i] = 1'($urandom_range(1, 0));
        return v;
    endfunction

    task automatic compare();
        bit exp_room;
        if (!chk_en) return;
        exp_room = (m_q.size() < DEPTH);
        chk_v("req_rdy", 32'(req_rdy), 32'(dma_rd_req_rdy && (m_cred != 0)));
        chk_v("dma_rd_req_vld", 32'(dma_rd_req_vld), 32'(req_vld && (m_cred != 0)));
        chk_v("dma_rd_req_pd_lo", dma_rd_req_pd[31:0], req_pd[31:0]);
        chk_v("credit_cnt", 32'(credit_cnt), 32'(m_cred));
        chk_v("credit_le_depth", 32'(credit_cnt <= CNT_W'(DEPTH)), 32'd1);
        chk_v("dma_rd_rsp_rdy", 32'(dma_rd_rsp_rdy), 32'(exp_room));
        chk_v("rsp_vld", 32'(rsp_vld), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk_pd("rsp_pd", rsp_pd, m_q[0]);
        chk_v("cdt_pop", 32'(cdt_pop), 32'(m_cdt));
        chk_v("idle", 32'(idle), 32'((m_cred == DEPTH) && (m_q.size() == 0) && !m_cdt));
        chk_v("err_ovf", 32'(err_ovf), 32'(m_err));
        if (prev_stall && rsp_vld) chk_pd("rsp_pd_hold", rsp_pd, prev_pd);
        prev_stall = rsp_vld && !rsp_rdy && !rst;
        prev_pd    = rsp_pd;
        if (req_vld && req_rdy) acc_cnt++;
        if (cdt_pop) cdt_cnt++;
    endtask

    task automatic model_update();
        bit acc, pop, wr;
        if (rst) begin
            m_q.delete();
            pend.delete();
            m_cred = DEPTH;
            m_cdt  = 1'b0;
            m_err  = 1'b0;
            return;
        end
        acc = req_vld && dma_rd_req_rdy && (m_cred != 0);
        pop = rsp_rdy && (m_q.size() != 0);
        wr  = dma_rd_rsp_vld && (m_q.size() < DEPTH);
        if (dma_rd_rsp_vld && (m_q.size() == DEPTH)) m_err = 1'b1;
        m_cred = m_cred - int'(acc) + int'(pop);
        m_cdt  = pop;
        if (pop) void'(m_q.pop_front());
        if (wr) begin
            m_q.push_back(dma_rd_rsp_pd);
            if (pend.size() != 0) void'(pend.pop_front());
        end
        if (acc) pend.push_back(cyc + int'($urandom_range(del_max, del_min)));
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge,
    // then drive new inputs just after it.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        req_pd        = rand_req();
        dma_rd_rsp_pd = rand_rsp();
        if (auto_rsp) begin
            dma_rd_rsp_vld = (pend.size() != 0) && (pend[0] <= cyc) &&
                             (!rsp_rand || ($urandom_range(9, 0) < 7));
        end
    endtask

    initial begin
        int acc_base;
        int cdt_base;
        int zero_seen;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk_v("rst_credit", 32'(credit_cnt), 32'd16);
        chk_v("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk_v("rst_cdt_pop", 32'(cdt_pop), 32'd0);
        chk_v("rst_err_ovf", 32'(err_ovf), 32'd0);
        chk_v("rst_idle", 32'(idle), 32'd1);

        // Exhaust credits with no responses
        acc_base       = acc_cnt;
        dma_rd_req_rdy = 1'b1;
        req_vld        = 1'b1;
        rsp_rdy        = 1'b0;
        repeat (20) tick();
        chk_v("fill_accepts", 32'(acc_cnt - acc_base), 32'd16);
        chk_v("fill_credit", 32'(credit_cnt), 32'd0);
        chk_v("fill_req_rdy", 32'(req_rdy), 32'd0);
        chk_v("fill_model_credit", 32'(m_cred), 32'd0);

        // Return 16 responses, then drain them
        req_vld        = 1'b0;
        dma_rd_rsp_vld = 1'b1;
        repeat (16) tick();
        chk_v("full_rsp_rdy", 32'(dma_rd_rsp_rdy), 32'd0);
        dma_rd_rsp_vld = 1'b0;
        cdt_base       = cdt_cnt;
        rsp_rdy        = 1'b1;
        repeat (20) tick();
        chk_v("drain_cdt_pulses", 32'(cdt_cnt - cdt_base), 32'd16);
        chk_v("drain_credit", 32'(credit_cnt), 32'd16);
        chk_v("drain_idle", 32'(idle), 32'd1);
        chk_v("drain_model_empty", 32'(m_q.size()), 32'd0);

        // Steady streaming, response three cycles after each request
        del_min   = 3;
        del_max   = 3;
        auto_rsp  = 1'b1;
        rsp_rand  = 1'b0;
        acc_base  = acc_cnt;
        zero_seen = 0;
        req_vld   = 1'b1;
        repeat (60) begin
            tick();
            if (credit_cnt == '0) zero_seen++;
        end
        req_vld = 1'b0;
        chk_v("stream_accepts", 32'(acc_cnt - acc_base), 32'd60);
        chk_v("stream_credit_zero_seen", 32'(zero_seen), 32'd0);
        repeat (15) tick();
        chk_v("stream_idle", 32'(idle), 32'd1);
        chk_v("stream_err_ovf", 32'(err_ovf), 32'd0);

        // One credit left: accept and pop in the same cycle
        auto_rsp       = 1'b0;
        dma_rd_rsp_vld = 1'b0;
        rsp_rdy        = 1'b0;
        acc_base       = acc_cnt;
        cdt_base       = cdt_cnt;
        req_vld        = 1'b1;
        repeat (15) tick();
        req_vld        = 1'b0;
        dma_rd_rsp_vld = 1'b1;
        tick();
        dma_rd_rsp_vld = 1'b0;
        tick();
        chk_v("one_credit", 32'(credit_cnt), 32'd1);
        chk_v("one_rsp_vld", 32'(rsp_vld), 32'd1);
        req_vld = 1'b1;
        rsp_rdy = 1'b1;
        #1;
        chk_v("one_req_rdy", 32'(req_rdy), 32'd1);
        tick();
        req_vld = 1'b0;
        rsp_rdy = 1'b0;
        chk_v("same_cycle_credit", 32'(credit_cnt), 32'd1);
        chk_v("same_cycle_cdt_pop", 32'(cdt_pop), 32'd1);
        tick();
        chk_v("same_cycle_cdt_pop_end", 32'(cdt_pop), 32'd0);
        chk_v("same_cycle_credit_hold", 32'(credit_cnt), 32'd1);

        // Random traffic with consumer backpressure, then drain
        del_min  = 1;
        del_max  = 6;
        auto_rsp = 1'b1;
        rsp_rand = 1'b1;
        repeat (400) begin
            tick();
            req_vld        = ($urandom_range(9, 0) < 7);
            dma_rd_req_rdy = ($urandom_range(9, 0) < 8);
            rsp_rdy        = 1'($urandom_range(1, 0));
        end
        req_vld  = 1'b0;
        rsp_rdy  = 1'b1;
        rsp_rand = 1'b0;
        repeat (40) tick();
        chk_v("rand_cdt_eq_req", 32'(cdt_cnt - cdt_base), 32'(acc_cnt - acc_base));
        chk_v("rand_credit", 32'(credit_cnt), 32'd16);
        chk_v("rand_idle", 32'(idle), 32'd1);

        // Reset with 5 buffered and 3 outstanding, pop requested during reset
        auto_rsp       = 1'b0;
        dma_rd_rsp_vld = 1'b0;
        rsp_rdy        = 1'b0;
        dma_rd_req_rdy = 1'b1;
        req_vld        = 1'b1;
        repeat (8) tick();
        req_vld        = 1'b0;
        dma_rd_rsp_vld = 1'b1;
        repeat (5) tick();
        dma_rd_rsp_vld = 1'b0;
        tick();
        chk_v("prerst_credit", 32'(credit_cnt), 32'd8);
        chk_v("prerst_rsp_vld", 32'(rsp_vld), 32'd1);
        rst     = 1'b1;
        rsp_rdy = 1'b1;
        tick();
        rst     = 1'b0;
        rsp_rdy = 1'b0;
        chk_v("midrst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk_v("midrst_credit", 32'(credit_cnt), 32'd16);
        chk_v("midrst_cdt_pop", 32'(cdt_pop), 32'd0);
        chk_v("midrst_err_ovf", 32'(err_ovf), 32'd0);
        chk_v("midrst_idle", 32'(idle), 32'd1);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
